motor_pwm_sched: RTL and testbench

//  Upstream of the per-axis MotorLogic H-bridge decoders. Generates 4 PWM waveforms,

---
 rtl/motor_pwm_sched.sv | 155 +++++++++++++++
 tb/tb_motor_pwm_sched.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/motor_pwm_sched.sv
// rtl/motor_pwm_sched.sv - 4-axis PWM generator with periodic back-EMF sampling windows
module motor_pwm_sched #(
  parameter int DUTY_W     = 8,
  parameter int PRESCALE_W = 8,
  parameter int ACK_TMO    = 255
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [2:0]  Addr,
  input  logic [15:0] DataWr,
  output logic [15:0] DataRd,
  input  logic        En,
  input  logic        Rd,
  input  logic        Wr,
  output logic [3:0]  PwmOut,
  output logic [7:0]  PwmCont,
  output logic [3:0]  Active,
  output logic        SampleReq,
  input  logic        SampleAck
);

  localparam logic [DUTY_W-1:0] CNT_LAST = DUTY_W'((2 ** DUTY_W) - 2);
  localparam int                TMO_W    = $clog2(ACK_TMO + 1);
  localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(ACK_TMO - 1);

  typedef enum logic [1:0] {RUN, SETTLE, SAMPLE, RECOVER} stateT;

  stateT                 state, nextState;
  logic [DUTY_W-1:0]     dutyShadow [4];
  logic [DUTY_W-1:0]     actDuty [4];
  logic [DUTY_W-1:0]     pwmCnt;
  logic [PRESCALE_W-1:0] prescale, preCnt;
  logic [7:0]            interval, settle, periodCnt, tickCnt;
  logic [TMO_W-1:0]      tmoCnt;
  logic                  ackTimeout;
  logic                  wrEn, tick, periodEnd;
  logic                  enterSettle, startSample, timedOut, endWindow;
  logic                  unusedRd;

  assign unusedRd  = Rd;
  assign wrEn      = Wr & En;
  assign tick      = (preCnt == prescale);
  assign periodEnd = tick && (pwmCnt == CNT_LAST);

  always_ff @(posedge Clk) begin
    if (Reset) state <= RUN;
    else       state <= nextState;
  end

  always_comb begin
    nextState   = state;
    enterSettle = 1'b0;
    startSample = 1'b0;
    timedOut    = 1'b0;
    endWindow   = 1'b0;
    case (state)
      RUN: if (periodEnd && interval != 8'd0 && periodCnt == interval - 8'd1) begin
        nextState   = SETTLE;
        enterSettle = 1'b1;
      end
      SETTLE: if (tick && tickCnt == settle) begin
        nextState   = SAMPLE;
        startSample = 1'b1;
      end
      // an ack arriving on the last allowed cycle still counts as a good sample
      SAMPLE: if (SampleAck) begin
        nextState = RECOVER;
      end else if (tmoCnt == TMO_LAST) begin
        nextState = RECOVER;
        timedOut  = 1'b1;
      end
      RECOVER: if (periodEnd) begin
        nextState = RUN;
        endWindow = 1'b1;
      end
      default: nextState = RUN;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < 4; i++) begin
        dutyShadow[i] <= '0;
        actDuty[i]    <= '0;
      end
      pwmCnt     <= '0;
      prescale   <= '0;
      preCnt     <= '0;
      interval   <= '0;
      settle     <= '0;
      periodCnt  <= '0;
      tickCnt    <= '0;
      tmoCnt     <= '0;
      ackTimeout <= 1'b0;
      PwmOut     <= '0;
      PwmCont    <= '0;
      Active     <= 4'hF;
      SampleReq  <= 1'b0;
    end else begin
      if (wrEn) begin
        case (Addr)
          3'd0, 3'd1, 3'd2, 3'd3: dutyShadow[Addr[1:0]] <= DataWr[DUTY_W-1:0];
          3'd4: PwmCont <= DataWr[7:0];
          3'd5: prescale <= DataWr[PRESCALE_W-1:0];
          3'd6: begin
            interval <= DataWr[7:0];
            settle   <= DataWr[15:8];
          end
          default: ;
        endcase
      end

      if ((wrEn && Addr == 3'd5) || tick) preCnt <= '0;
      else                                preCnt <= preCnt + 1'b1;

      if (tick) pwmCnt <= periodEnd ? '0 : pwmCnt + 1'b1;

      // shadow values written this cycle are not yet visible here, so they wait a period
      for (int i = 0; i < 4; i++) begin
        if (periodEnd) actDuty[i] <= dutyShadow[i];
        PwmOut[i] <= (actDuty[i] > pwmCnt);
      end

      if (endWindow || enterSettle || (state == RUN && interval == 8'd0)) periodCnt <= '0;
      else if (state == RUN && periodEnd)                                 periodCnt <= periodCnt + 1'b1;

      if (enterSettle)                  tickCnt <= '0;
      else if (state == SETTLE && tick) tickCnt <= tickCnt + 1'b1;

      if (startSample)          tmoCnt <= '0;
      else if (state == SAMPLE) tmoCnt <= tmoCnt + 1'b1;

      if (enterSettle)    Active <= 4'h0;
      else if (endWindow) Active <= 4'hF;

      SampleReq <= startSample;

      if (timedOut)                    ackTimeout <= 1'b1;
      else if (wrEn && Addr == 3'd7)   ackTimeout <= 1'b0;
    end
  end

  always_comb begin
    DataRd = '0;
    case (Addr)
      3'd0, 3'd1, 3'd2, 3'd3: DataRd[DUTY_W-1:0] = dutyShadow[Addr[1:0]];
      3'd4: DataRd[7:0] = PwmCont;
      3'd5: DataRd[PRESCALE_W-1:0] = prescale;
      3'd6: DataRd = {settle, interval};
      3'd7: DataRd[5:0] = {ackTimeout, (state != RUN), Active};
      default: ;
    endcase
  end

endmodule

// File: tb/tb_motor_pwm_sched.sv
// tb/tb_motor_pwm_sched.sv - directed self-checking bench for motor_pwm_sched
module tb_motor_pwm_sched;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic [2:0]  Addr = '0;
  logic [15:0] DataWr = '0;
  logic [15:0] DataRd;
  logic        En = 1'b0;
  logic        Rd = 1'b0;
  logic        Wr = 1'b0;
  logic [3:0]  PwmOut;
  logic [7:0]  PwmCont;
  logic [3:0]  Active;
  logic        SampleReq;
  logic        SampleAck = 1'b0;

  int nChecks = 0;
  int nErrors = 0;

  motor_pwm_sched dut (
    .Clk(Clk), .Reset(Reset), .Addr(Addr), .DataWr(DataWr), .DataRd(DataRd),
    .En(En), .Rd(Rd), .Wr(Wr), .PwmOut(PwmOut), .PwmCont(PwmCont),
    .Active(Active), .SampleReq(SampleReq), .SampleAck(SampleAck)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nErrors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic busWrite(input logic [2:0] a, input logic [15:0] d);
    Addr = a; DataWr = d; En = 1'b1; Wr = 1'b1;
    step();
    En = 1'b0; Wr = 1'b0;
  endtask

  task automatic readCheck(input logic [2:0] a, input logic [15:0] exp, input string tag);
    Addr = a; En = 1'b1; Rd = 1'b1;
    #1;
    check(tag, 32'(DataRd), 32'(exp));
    En = 1'b0; Rd = 1'b0;
    step();
  endtask

  // Sample indices are counted in cycles from the call; -1 means the event was never seen.
  task automatic watchWindow(input bit giveAck, input bit earlyAck, input int maxCyc,
                             output int aIdx, output int riseAfter, output int risesBefore,
                             output int sIdx, output int tIdx, output int restIdx,
                             output int reqCount, output logic [15:0] statAtReq);
    logic prev;
    aIdx = -1; riseAfter = -1; risesBefore = 0; sIdx = -1; tIdx = -1; restIdx = -1;
    reqCount = 0; statAtReq = '0;
    Addr = 3'd7;
    prev = PwmOut[0];
    for (int i = 1; i <= maxCyc && restIdx < 0; i++) begin
      SampleAck = (giveAck && sIdx >= 0 && i - 1 == sIdx + 5) ||
                  (earlyAck && aIdx >= 0 && i - 1 == aIdx + 5);
      step();
      if (PwmOut[0] && !prev) begin
        if (aIdx < 0) risesBefore++;
        else if (riseAfter < 0) riseAfter = i;
      end
      if (aIdx < 0 && Active == 4'h0) aIdx = i;
      if (SampleReq) begin
        reqCount++;
        if (sIdx < 0) begin
          sIdx = i;
          statAtReq = DataRd;
        end
      end
      if (tIdx < 0 && DataRd[5]) tIdx = i;
      if (aIdx >= 0 && restIdx < 0 && Active == 4'hF) restIdx = i;
      prev = PwmOut[0];
    end
    SampleAck = 1'b0;
  endtask

  initial begin
    int h0, h1, h2, h3, notF, reqs, cnt, found;
    int aIdx, riseAfter, risesBefore, sIdx, tIdx, restIdx, reqCount;
    logic [15:0] statAtReq;
    logic prev;

    repeat (3) step();
    check("rst_pwmout", 32'(PwmOut), 32'h0);
    check("rst_pwmcont", 32'(PwmCont), 32'h0);
    check("rst_active", 32'(Active), 32'hF);
    check("rst_samplereq", 32'(SampleReq), 32'h0);
    Reset = 1'b0;
    for (int a = 0; a < 7; a++) readCheck(3'(a), 16'h0000, "rst_reg");
    readCheck(3'd7, 16'h000F, "rst_status");

    // Prescale 0, windows disabled, four duty patterns including both extremes
    busWrite(3'd0, 16'd128);
    busWrite(3'd1, 16'd50);
    busWrite(3'd2, 16'd0);
    busWrite(3'd3, 16'd255);
    busWrite(3'd6, 16'h0000);
    busWrite(3'd4, 16'h00A5);
    check("pwmcont_next_clk", 32'(PwmCont), 32'hA5);
    readCheck(3'd0, 16'h0080, "rd_duty0");
    readCheck(3'd1, 16'h0032, "rd_duty1");
    readCheck(3'd3, 16'h00FF, "rd_duty3");
    readCheck(3'd4, 16'h00A5, "rd_pwmcont");
    notF = 0; reqs = 0; h0 = 0; h1 = 0; h2 = 0; h3 = 0;
    repeat (520) begin
      step();
      if (Active !== 4'hF) notF++;
      if (SampleReq) reqs++;
    end
    repeat (765) begin
      step();
      if (PwmOut[0]) h0++;
      if (PwmOut[1]) h1++;
      if (PwmOut[2]) h2++;
      if (PwmOut[3]) h3++;
      if (Active !== 4'hF) notF++;
      if (SampleReq) reqs++;
    end
    check("duty128_highs_3per", 32'(h0), 32'd384);
    check("duty50_highs_3per", 32'(h1), 32'd150);
    check("duty0_const_low", 32'(h2), 32'd0);
    check("duty255_const_high", 32'(h3), 32'd765);
    check("interval0_active", 32'(notF), 32'd0);
    check("interval0_noreq", 32'(reqs), 32'd0);

    // Align to the period: a rise of PwmOut[0] is seen two cycles after PeriodEnd
    prev = PwmOut[0]; found = 0;
    for (int i = 0; i < 600 && found == 0; i++) begin
      step();
      if (PwmOut[0] && !prev) found = 1;
      prev = PwmOut[0];
    end
    check("t2_phase_found", 32'(found), 32'd1);
    repeat (253) step();
    busWrite(3'd1, 16'd200);
    cnt = 0;
    repeat (255) begin step(); if (PwmOut[1]) cnt++; end
    check("t2_old_duty_period", 32'(cnt), 32'd50);
    cnt = 0;
    repeat (255) begin step(); if (PwmOut[1]) cnt++; end
    check("t2_new_duty_period", 32'(cnt), 32'd200);
    readCheck(3'd1, 16'h00C8, "rd_duty1_new");

    // Window with acknowledged sample
    busWrite(3'd5, 16'd1);
    readCheck(3'd5, 16'h0001, "rd_prescale");
    busWrite(3'd6, 16'h0A04);
    readCheck(3'd6, 16'h0A04, "rd_interval_settle");
    watchWindow(1'b1, 1'b0, 3500, aIdx, riseAfter, risesBefore, sIdx, tIdx, restIdx,
                reqCount, statAtReq);
    check("t3_periodends_before", 32'(risesBefore), 32'd3);
    check("t3_fall_at_4th_pe", 32'(riseAfter - aIdx), 32'd1);
    check("t3_req_delay", 32'(sIdx - aIdx), 32'd22);
    check("t3_req_count", 32'(reqCount), 32'd1);
    check("t3_status_in_window", 32'(statAtReq), 32'h0010);
    check("t3_no_timeout", 32'(tIdx), 32'hFFFF_FFFF);
    check("t3_restore_delay", 32'(restIdx - aIdx), 32'd510);
    check("t3_status_after", 32'(DataRd), 32'h000F);

    // Window without a real ack; an ack during SETTLE must be ignored
    watchWindow(1'b0, 1'b1, 3500, aIdx, riseAfter, risesBefore, sIdx, tIdx, restIdx,
                reqCount, statAtReq);
    check("t4_req_delay", 32'(sIdx - aIdx), 32'd22);
    check("t4_timeout_delay", 32'(tIdx - sIdx), 32'd255);
    check("t4_restore_delay", 32'(restIdx - aIdx), 32'd510);
    check("t4_req_count", 32'(reqCount), 32'd1);
    check("t4_status_sticky", 32'(DataRd), 32'h002F);
    busWrite(3'd7, 16'h0000);
    check("t4_status_cleared", 32'(DataRd), 32'h000F);

    // Reset in the middle of SETTLE
    found = 0;
    for (int i = 0; i < 3000 && found == 0; i++) begin
      step();
      if (Active == 4'h0) found = 1;
    end
    check("t5_window_open", 32'(found), 32'd1);
    repeat (5) step();
    check("t5_in_settle", 32'(Active), 32'h0);
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    check("t5_active", 32'(Active), 32'hF);
    check("t5_pwmout", 32'(PwmOut), 32'h0);
    check("t5_pwmcont", 32'(PwmCont), 32'h0);
    for (int a = 0; a < 7; a++) readCheck(3'(a), 16'h0000, "t5_reg_zero");
    readCheck(3'd7, 16'h000F, "t5_status");
    notF = 0; reqs = 0; cnt = 0;
    repeat (600) begin
      step();
      if (Active !== 4'hF) notF++;
      if (SampleReq) reqs++;
      if (PwmOut != 4'h0) cnt++;
    end
    check("t5_window_abandoned", 32'(notF), 32'd0);
    check("t5_no_req", 32'(reqs), 32'd0);
    check("t5_pwm_low", 32'(cnt), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule
